frame_bram_sequencer: RTL and testbench
=======================================

Name: frame_bram_sequencer

Overview:
- Owns the full-frame 24-bit output image BRAM and shares its ports among three phases in a fixed sequence: clear to a constant, pass-through of lane-highlight writes, and paced readout into an output FIFO.
- Replaces ad-hoc phase muxing in top levels.
- Emits the clear-complete pulse that starts the highlight engine, and a frame-complete pulse.

Parameters:
- WIDTH, 1280, frame width in pixels.
- HEIGHT, 720, frame height in pixels.
- IMAGE_SIZE, WIDTH*HEIGHT, pixel count and BRAM depth.
- ADDR_BITS, $clog2(IMAGE_SIZE), BRAM address width.
- CLEAR_VALUE, 24'h000000, pixel value written during clear.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- clear_done  out  1  one-cycle pulse when clear completes; drives the highlight engine's hough_done.
- hl_wr_en  in  1  highlight write request.
- hl_wr_addr  in  ADDR_BITS  highlight write address.
- hl_wr_data  in  24  highlight write data.
- hl_done  in  1  highlight engine finished.
- bram_wr_en  out  1  BRAM write enable.
- bram_wr_addr  out  ADDR_BITS  BRAM write address.
- bram_wr_data  out  24  BRAM write data.
- bram_rd_addr  out  ADDR_BITS  BRAM read address; data returns on the next clock.
- bram_rd_data  in  24  BRAM read data.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  output FIFO write.
- out_din  out  24  output FIFO data.
- frame_done  out  1  one-cycle pulse after the last pixel is pushed.
- oob_err  out  1  sticky flag: highlight write address was out of range.

Behaviour:
- States: IDLE, CLEAR, HIGHLIGHT, READ. Flat pixel counter idx ranges 0..IMAGE_SIZE-1; addresses are linear (row-major).
- Reset: state=IDLE, idx=0, skid register empty. busy, clear_done, frame_done, oob_err, out_wr_en and bram_wr_en are all 0. All addresses and data outputs are 0.
- IDLE:
  - start=1 -> CLEAR next cycle; idx=0; oob_err cleared.
  - No BRAM writes. hl_* inputs are ignored.
- CLEAR:
  - Every cycle: bram_wr_en=1, bram_wr_addr=idx, bram_wr_data=CLEAR_VALUE; idx increments.
  - The write with idx=IMAGE_SIZE-1 is the last. The next cycle is HIGHLIGHT with clear_done=1 for exactly that cycle.
  - Clear takes exactly IMAGE_SIZE cycles.
- HIGHLIGHT:
  - bram_wr_* follow hl_wr_* combinationally, same cycle.
  - If hl_wr_addr >= IMAGE_SIZE: write suppressed (bram_wr_en=0) and oob_err set. oob_err stays set until the next accepted start.
  - hl_done=1 -> READ next cycle, idx=0. A hl_wr_en in the same cycle as hl_done is still written.
  - hl_wr_en outside HIGHLIGHT is never forwarded.
- READ (1-cycle BRAM latency, one-entry skid register):
  - Issue condition: read of idx is issued in a cycle when idx<IMAGE_SIZE, the skid is empty, and out_full=0. idx then increments.
  - Next cycle, returned data: if out_full=0 it is pushed directly (out_wr_en=1, out_din=bram_rd_data); otherwise it is captured into the skid.
  - While the skid is full, no issue occurs. The skid drains (out_wr_en=1, out_din=skid) on the first cycle with out_full=0.
  - out_wr_en is never asserted while out_full=1.
  - Pixels are pushed exactly once each, in address order.
  - Sustained rate is 1 pixel/cycle when out_full=0 throughout.
  - The cycle after pixel IMAGE_SIZE-1 is pushed: frame_done=1 for one cycle, state=IDLE.
- bram_rd_addr: equals idx on issue cycles; otherwise holds its last value. Value is 0 after reset.
- bram_wr_en: 0 in IDLE and READ.
- start asserted while busy: ignored, no effect.
- Reset asserted mid-frame (any state): immediate return to reset values. Any in-flight read data and skid contents are discarded. No further FIFO writes.
- Total frame latency with no backpressure: 1 cycle (IDLE->CLEAR) + IMAGE_SIZE (CLEAR) + highlight time + IMAGE_SIZE+1 (READ) cycles.

Test Plan:
- Use WIDTH=4, HEIGHT=3 (IMAGE_SIZE=12). start pulse, hl_done after 5 cycles, no writes, out_full=0 -> 12 CLEAR writes to addr 0..11 with 0x000000. clear_done pulses once, 13 cycles after start. 12 FIFO pushes of 0x000000. frame_done one cycle after the 12th push.
- In HIGHLIGHT: hl writes addr 5=0xFF0000 and addr 11=0x00FF00; hl_done in the same cycle as the addr 11 write -> readout index 5=0xFF0000, index 11=0x00FF00, all others 0.
- In HIGHLIGHT: hl_wr_addr=12 -> no BRAM write, oob_err=1 through frame end. oob_err clears on the next start.
- During READ: out_full toggles 1,0 every cycle, plus a 4-cycle full burst after pixel 3 -> exactly 12 pushes in order 0..11, none while full, no duplicates.
- start pulsed during CLEAR and READ -> ignored. Exactly one clear_done and one frame_done per frame.
- reset asserted at pixel 7 of READ, then start -> no pushes after reset. The new frame restarts CLEAR at addr 0.

Source files
------------

// File: rtl/frame_bram_sequencer.sv
// Frame BRAM sequencer: owns the output image BRAM and walks it through three phases per frame:
// clear to a constant, pass-through of highlight-engine writes, then paced readout into the
// output FIFO through a one-entry skid register that absorbs the BRAM read latency.
module frame_bram_sequencer #(
  parameter int unsigned WIDTH       = 1280,
  parameter int unsigned HEIGHT      = 720,
  parameter int unsigned IMAGE_SIZE  = WIDTH * HEIGHT,
  parameter int unsigned ADDR_BITS   = $clog2(IMAGE_SIZE),
  parameter logic [23:0] CLEAR_VALUE = 24'h000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 clear_done,
  input  logic                 hl_wr_en,
  input  logic [ADDR_BITS-1:0] hl_wr_addr,
  input  logic [23:0]          hl_wr_data,
  input  logic                 hl_done,
  output logic                 bram_wr_en,
  output logic [ADDR_BITS-1:0] bram_wr_addr,
  output logic [23:0]          bram_wr_data,
  output logic [ADDR_BITS-1:0] bram_rd_addr,
  input  logic [23:0]          bram_rd_data,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [23:0]          out_din,
  output logic                 frame_done,
  output logic                 oob_err
);

  // One extra bit so the readout counter can sit at IMAGE_SIZE once every read is issued.
  localparam int unsigned IdxBits = ADDR_BITS + 1;
  localparam logic [IdxBits-1:0] IdxLast = IdxBits'(IMAGE_SIZE - 1);
  localparam logic [IdxBits-1:0] IdxEnd  = IdxBits'(IMAGE_SIZE);
  localparam logic [IdxBits-1:0] IdxOne  = IdxBits'(1);

  typedef enum logic [1:0] {StIdle, StClear, StHighlight, StRead} state_e;

  state_e               state_q, state_d;
  logic [IdxBits-1:0]   idx_q, idx_d;
  logic                 rd_pending_q, rd_pending_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [23:0]          skid_data_q, skid_data_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 clear_done_q, clear_done_d;
  logic                 frame_done_q, frame_done_d;
  logic                 oob_err_q, oob_err_d;
  logic                 hl_in_range;
  logic                 issue;
  logic                 push;

  assign hl_in_range = {1'b0, hl_wr_addr} < IdxEnd;

  // State and datapath registers; reset discards any in-flight read and skid contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      rd_pending_q <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      rd_addr_q    <= '0;
      clear_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      oob_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_pending_q <= rd_pending_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      rd_addr_q    <= rd_addr_d;
      clear_done_q <= clear_done_d;
      frame_done_q <= frame_done_d;
      oob_err_q    <= oob_err_d;
    end
  end

  // Phase sequencing, BRAM port muxing and FIFO push/skid control.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_pending_d = 1'b0;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    rd_addr_d    = rd_addr_q;
    clear_done_d = 1'b0;
    frame_done_d = 1'b0;
    oob_err_d    = oob_err_q;
    bram_wr_en   = 1'b0;
    bram_wr_addr = '0;
    bram_wr_data = '0;
    out_wr_en    = 1'b0;
    out_din      = '0;
    issue        = 1'b0;
    push         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StClear;
          idx_d     = '0;
          oob_err_d = 1'b0;
        end
      end

      StClear: begin
        bram_wr_en   = 1'b1;
        bram_wr_addr = idx_q[ADDR_BITS-1:0];
        bram_wr_data = CLEAR_VALUE;
        if (idx_q == IdxLast) begin
          state_d      = StHighlight;
          idx_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IdxOne;
        end
      end

      StHighlight: begin
        bram_wr_addr = hl_wr_addr;
        bram_wr_data = hl_wr_data;
        if (hl_wr_en) begin
          if (hl_in_range) begin
            bram_wr_en = 1'b1;
          end else begin
            oob_err_d = 1'b1;
          end
        end
        if (hl_done) begin
          state_d = StRead;
          idx_d   = '0;
        end
      end

      StRead: begin
        // At most one pixel is outstanding (pending read or skid), so issue needs an empty skid.
        issue = (idx_q < IdxEnd) && !skid_valid_q && !out_full;
        if (skid_valid_q) begin
          if (!out_full) begin
            push         = 1'b1;
            out_din      = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end else if (rd_pending_q) begin
          if (!out_full) begin
            push    = 1'b1;
            out_din = bram_rd_data;
          end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = bram_rd_data;
          end
        end
        out_wr_en = push;
        if (issue) begin
          rd_pending_d = 1'b1;
          rd_addr_d    = idx_q[ADDR_BITS-1:0];
          idx_d        = idx_q + IdxOne;
        end
        // Once every read is issued, any push is the final pixel.
        if (push && (idx_q == IdxEnd)) begin
          state_d      = StIdle;
          idx_d        = '0;
          frame_done_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    bram_rd_addr = issue ? idx_q[ADDR_BITS-1:0] : rd_addr_q;
  end

  assign busy       = (state_q != StIdle);
  assign clear_done = clear_done_q;
  assign frame_done = frame_done_q;
  assign oob_err    = oob_err_q;

endmodule

// File: tb/tb_frame_bram_sequencer.sv
// Directed bench for frame_bram_sequencer on a 4x3 frame with a behavioural 1-cycle BRAM.
module tb_frame_bram_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned N  = W * H;
  localparam int unsigned AB = $clog2(N);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          clear_done;
  logic          hl_wr_en;
  logic [AB-1:0] hl_wr_addr;
  logic [23:0]   hl_wr_data;
  logic          hl_done;
  logic          bram_wr_en;
  logic [AB-1:0] bram_wr_addr;
  logic [23:0]   bram_wr_data;
  logic [AB-1:0] bram_rd_addr;
  logic [23:0]   bram_rd_data;
  logic          out_full;
  logic          out_wr_en;
  logic [23:0]   out_din;
  logic          frame_done;
  logic          oob_err;

  frame_bram_sequencer #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .CLEAR_VALUE (24'h000000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .clear_done   (clear_done),
    .hl_wr_en     (hl_wr_en),
    .hl_wr_addr   (hl_wr_addr),
    .hl_wr_data   (hl_wr_data),
    .hl_done      (hl_done),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data),
    .out_full     (out_full),
    .out_wr_en    (out_wr_en),
    .out_din      (out_din),
    .frame_done   (frame_done),
    .oob_err      (oob_err)
  );

  always #5 clock = ~clock;

  // Behavioural BRAM, preloaded with a non-zero pattern so the clear phase is visible.
  logic [23:0] mem [16] = '{default: 24'hABCDEF};
  always @(posedge clock) begin
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
    bram_rd_data <= mem[bram_rd_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event log sampled mid-cycle.
  logic [AB-1:0] wr_addr_q[$];
  logic [23:0]   wr_data_q[$];
  logic [23:0]   push_q[$];
  int clear_cnt = 0, frame_cnt = 0, full_viol = 0;
  int clear_cyc = 0, frame_cyc = 0, last_push_cyc = 0;
  always @(negedge clock) begin
    if (bram_wr_en) begin
      wr_addr_q.push_back(bram_wr_addr);
      wr_data_q.push_back(bram_wr_data);
    end
    if (out_wr_en) begin
      push_q.push_back(out_din);
      last_push_cyc <= cyc;
      if (out_full) full_viol <= full_viol + 1;
    end
    if (clear_done) begin
      clear_cnt <= clear_cnt + 1;
      clear_cyc <= cyc;
    end
    if (frame_done) begin
      frame_cnt <= frame_cnt + 1;
      frame_cyc <= cyc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_clear(input int base);
    for (int k = 0; k < 60 && clear_cnt == base; k++) tick();
  endtask

  task automatic wait_frame(input int base);
    for (int k = 0; k < 200 && frame_cnt == base; k++) tick();
  endtask

  logic [23:0] exp_pix [N];
  int wb, wb2, pb, cb, fb, c0, hc, pr, burst, burst_used;
  logic tog;

  initial begin
    reset = 1'b1; start = 1'b0; hl_wr_en = 1'b0; hl_wr_addr = '0; hl_wr_data = '0;
    hl_done = 1'b0; out_full = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_oob", oob_err, 0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_bram_wr_en", bram_wr_en, 0);
    check("rst_rd_addr", bram_rd_addr, 0);
    check("rst_wr_addr", bram_wr_addr, 0);
    check("rst_wr_data", bram_wr_data, 0);
    check("rst_out_din", out_din, 0);
    reset = 1'b0;
    tick();

    // Highlight inputs are ignored in IDLE.
    hl_wr_en = 1'b1; hl_wr_addr = 4'd3; hl_wr_data = 24'h111111;
    #1;
    check("idle_hl_ignored", bram_wr_en, 0);
    tick();
    hl_wr_en = 1'b0;

    // Frame 1: plain clear and readout, no backpressure.
    wb = wr_addr_q.size(); pb = push_q.size(); cb = clear_cnt; fb = frame_cnt;
    start = 1'b1; c0 = cyc;
    tick();
    start = 1'b0;
    check("f1_busy", busy, 1);
    wait_clear(cb);
    check("f1_clear_cnt", clear_cnt - cb, 1);
    check("f1_clear_lat", clear_cyc - c0, 13);
    check("f1_clear_writes", wr_addr_q.size() - wb, N);
    if (wr_addr_q.size() - wb >= N) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("f1_clr_addr%0d", i), wr_addr_q[wb + i], i);
        check($sformatf("f1_clr_data%0d", i), wr_data_q[wb + i], 0);
      end
    end
    repeat (4) tick();
    hl_done = 1'b1; hc = cyc;
    tick();
    hl_done = 1'b0;
    wait_frame(fb);
    check("f1_frame_cnt", frame_cnt - fb, 1);
    check("f1_read_lat", frame_cyc - hc, N + 2);
    check("f1_done_after_push", frame_cyc - last_push_cyc, 1);
    check("f1_push_cnt", push_q.size() - pb, N);
    if (push_q.size() - pb >= N) begin
      for (int i = 0; i < N; i++) check($sformatf("f1_pix%0d", i), push_q[pb + i], 0);
    end
    check("f1_busy_end", busy, 0);
    check("f1_oob", oob_err, 0);
    check("f1_clear_cnt_end", clear_cnt - cb, 1);

    // Frame 2: highlight writes, out-of-range write, stray starts, backpressured readout.
    for (int i = 0; i < N; i++) exp_pix[i] = 24'h000000;
    exp_pix[5]  = 24'hFF0000;
    exp_pix[11] = 24'h00FF00;
    wb = wr_addr_q.size(); pb = push_q.size(); cb = clear_cnt; fb = frame_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_clear(cb);
    check("f2_clear_cnt", clear_cnt - cb, 1);
    check("f2_clear_writes", wr_addr_q.size() - wb, N);
    wb2 = wr_addr_q.size();
    hl_wr_en = 1'b1; hl_wr_addr = 4'd5; hl_wr_data = 24'hFF0000;
    #1;
    check("f2_hl5_en", bram_wr_en, 1);
    check("f2_hl5_addr", bram_wr_addr, 5);
    check("f2_hl5_data", bram_wr_data, 24'hFF0000);
    tick();
    hl_wr_addr = 4'd12; hl_wr_data = 24'h123456;
    #1;
    check("f2_oob_suppressed", bram_wr_en, 0);
    tick();
    check("f2_oob_set", oob_err, 1);
    hl_wr_addr = 4'd11; hl_wr_data = 24'h00FF00; hl_done = 1'b1;
    #1;
    check("f2_hl11_with_done", bram_wr_en, 1);
    tick();
    hl_wr_en = 1'b0; hl_done = 1'b0;
    burst = 0; burst_used = 0; tog = 1'b1;
    for (int k = 0; k < 200 && frame_cnt == fb; k++) begin
      if (burst_used == 0 && push_q.size() - pb >= 4) begin
        burst = 4;
        burst_used = 1;
      end
      if (burst > 0) begin
        out_full = 1'b1;
        burst--;
      end else begin
        out_full = tog;
        tog = ~tog;
      end
      start = (k == 6);
      tick();
    end
    out_full = 1'b0; start = 1'b0;
    check("f2_frame_cnt", frame_cnt - fb, 1);
    check("f2_push_cnt", push_q.size() - pb, N);
    check("f2_full_viol", full_viol, 0);
    check("f2_hl_writes", wr_addr_q.size() - wb2, 2);
    if (push_q.size() - pb >= N) begin
      for (int i = 0; i < N; i++) check($sformatf("f2_pix%0d", i), push_q[pb + i], exp_pix[i]);
    end
    check("f2_oob_sticky", oob_err, 1);
    repeat (2) tick();
    check("f2_start_in_read_ignored", busy, 0);
    check("f2_clear_cnt_end", clear_cnt - cb, 1);
    check("f2_frame_cnt_end", frame_cnt - fb, 1);

    // Frame 3: oob_err clears on start; reset mid-readout.
    pb = push_q.size(); cb = clear_cnt; fb = frame_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f3_oob_cleared", oob_err, 0);
    check("f3_clear_first_en", bram_wr_en, 1);
    check("f3_clear_first_addr", bram_wr_addr, 0);
    wait_clear(cb);
    hl_done = 1'b1;
    tick();
    hl_done = 1'b0;
    for (int k = 0; k < 100 && push_q.size() - pb < 7; k++) tick();
    check("f3_pushes_before_reset", push_q.size() - pb, 7);
    reset = 1'b1;
    #1;
    check("f3_rst_out_wr_en", out_wr_en, 0);
    check("f3_rst_busy", busy, 0);
    check("f3_rst_rd_addr", bram_rd_addr, 0);
    tick();
    reset = 1'b0;
    pr = push_q.size();
    repeat (6) tick();
    check("f3_no_push_after_reset", push_q.size(), pr);
    check("f3_no_frame_done", frame_cnt - fb, 0);

    // Frame 4: restarts clearing from address 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f4_busy", busy, 1);
    check("f4_clear_en", bram_wr_en, 1);
    check("f4_clear_addr0", bram_wr_addr, 0);
    tick();
    check("f4_clear_addr1", bram_wr_addr, 1);
    check("f4_clear_data", bram_wr_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
